// File: rtl/rx_block_buffer.sv
// Purpose : packs 32-bit words from the AHB slave into 128-bit key/data blocks and queues them for the AES core.
// Latency : o_blk_valid rises the cycle after the edge that accepts the last word of a block.
// Backpres: valid/ready pop; a completed block that finds the FIFO full (and no pop that edge) is dropped and flagged sticky.
//
// Build option: define RX_BYTE_SWAP_EN to byte-reverse each incoming word before it is stored.
//
// Ports:
//   clk, n_rst       clock, asynchronous active-low reset
//   i_shift_en       one word accepted per high cycle
//   i_word_in        incoming word
//   i_data_type      1 = key block, 0 = data block; sampled on the first word of a block
//   i_flush          synchronous clear of assembly, FIFO and status
//   i_blk_ready      consumer ready
//   o_blk_valid      FIFO head holds a block
//   o_blk_data       FIFO head block (word 0 in the MSBs)
//   o_blk_is_key     tag of the FIFO head
//   o_word_ct        words held in the assembly register
//   o_full, o_empty  FIFO occupancy status
//   o_overflow       sticky, a completed block was dropped
//   o_blk_count      blocks committed since reset/flush, wraps
module rx_block_buffer #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_BLK = 4,
  parameter int DEPTH         = 2
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              i_shift_en,
  input  logic [WORD_W-1:0]                 i_word_in,
  input  logic                              i_data_type,
  input  logic                              i_flush,
  input  logic                              i_blk_ready,
  output logic                              o_blk_valid,
  output logic [WORD_W*WORDS_PER_BLK-1:0]   o_blk_data,
  output logic                              o_blk_is_key,
  output logic [$clog2(WORDS_PER_BLK)-1:0]  o_word_ct,
  output logic                              o_full,
  output logic                              o_empty,
  output logic                              o_overflow,
  output logic [7:0]                        o_blk_count
);

  localparam int BLK_W = WORD_W * WORDS_PER_BLK;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(WORDS_PER_BLK);

  logic [BLK_W-1:0]  r_asm;
  logic              r_tag;
  logic [CW-1:0]     r_word_ct;
  logic [BLK_W-1:0]  r_mem [DEPTH];
  logic              r_mem_tag [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_occ;
  logic              r_overflow;
  logic [7:0]        r_blk_count;

  logic [WORD_W-1:0] w_word;
  logic [BLK_W-1:0]  w_asm_nxt;
  logic              w_tag_nxt;
  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

`ifdef RX_BYTE_SWAP_EN
  assign w_word = {i_word_in[7:0], i_word_in[15:8], i_word_in[23:16], i_word_in[31:24]};
`else
  assign w_word = i_word_in;
`endif

  // Assembly view including the word arriving this cycle, so the final word
  // can be committed on the same edge it is accepted.
  always_comb begin
    w_asm_nxt = r_asm;
    if (i_shift_en) begin
      for (int i = 0; i < WORDS_PER_BLK; i++) begin
        if (r_word_ct == CW'(i)) begin
          w_asm_nxt[(WORDS_PER_BLK-1-i)*WORD_W +: WORD_W] = w_word;
        end
      end
    end
  end

  assign w_tag_nxt = (r_word_ct == '0) ? i_data_type : r_tag;
  assign w_last    = i_shift_en && (r_word_ct == CW'(WORDS_PER_BLK-1));

  assign o_full  = (r_occ == (AW+1)'(DEPTH));
  assign o_empty = (r_occ == '0);

  // Flush wins over both a pop and a commit on the same edge.
  assign w_pop  = !o_empty && i_blk_ready && !i_flush;
  assign w_push = w_last && (!o_full || w_pop) && !i_flush;
  assign w_drop = w_last && o_full && !w_pop && !i_flush;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_asm     <= '0;
      r_tag     <= 1'b0;
      r_word_ct <= '0;
    end else if (i_flush) begin
      r_asm     <= '0;
      r_tag     <= 1'b0;
      r_word_ct <= '0;
    end else if (i_shift_en) begin
      r_asm     <= w_asm_nxt;
      r_tag     <= w_tag_nxt;
      r_word_ct <= r_word_ct + 1'b1;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read
  // combinationally before the edge, so overwriting that slot is safe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]     <= '0;
        r_mem_tag[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr]     <= w_asm_nxt;
      r_mem_tag[r_wr_ptr] <= w_tag_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_blk_count <= 8'd0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_blk_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_blk_count <= r_blk_count + 8'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_blk_valid  = !o_empty;
  assign o_blk_data   = r_mem[r_rd_ptr];
  assign o_blk_is_key = r_mem_tag[r_rd_ptr];
  assign o_word_ct    = r_word_ct;
  assign o_overflow   = r_overflow;
  assign o_blk_count  = r_blk_count;

endmodule

// File: tb/tb_rx_block_buffer.sv
// Purpose : directed bench for rx_block_buffer with a FIFO-order scoreboard of {tag, block}.
// Latency : inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
// Backpres: i_blk_ready held low to fill the FIFO, raised per pop.
module tb_rx_block_buffer;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         i_shift_en;
  logic [31:0]  i_word_in;
  logic         i_data_type;
  logic         i_flush;
  logic         i_blk_ready;
  logic         o_blk_valid;
  logic [127:0] o_blk_data;
  logic         o_blk_is_key;
  logic [1:0]   o_word_ct;
  logic         o_full;
  logic         o_empty;
  logic         o_overflow;
  logic [7:0]   o_blk_count;

  int checks   = 0;
  int failures = 0;
  logic [128:0] sb [$];

  rx_block_buffer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_shift_en   (i_shift_en),
    .i_word_in    (i_word_in),
    .i_data_type  (i_data_type),
    .i_flush      (i_flush),
    .i_blk_ready  (i_blk_ready),
    .o_blk_valid  (o_blk_valid),
    .o_blk_data   (o_blk_data),
    .o_blk_is_key (o_blk_is_key),
    .o_word_ct    (o_word_ct),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_overflow   (o_overflow),
    .o_blk_count  (o_blk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef RX_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift(input logic [31:0] w, input logic t);
    i_shift_en  = 1'b1;
    i_word_in   = w;
    i_data_type = t;
    cyc();
    i_shift_en  = 1'b0;
  endtask

  // Type t on word 0, inverted on the rest so a mid-block tag change is exercised.
  task automatic send_block(input logic [31:0] w0, w1, w2, w3, input logic t, input logic commits);
    shift(w0, t);
    shift(w1, !t);
    shift(w2, !t);
    if (commits) sb.push_back({t, sw(w0), sw(w1), sw(w2), sw(w3)});
    shift(w3, !t);
  endtask

  // Compare the FIFO head against the oldest expected block, consuming it.
  task automatic head_chk(input string tag);
    logic [128:0] e;
    chk({tag, "_valid"}, 128'(o_blk_valid), 128'(1'b1));
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty_scoreboard expected=pending_block", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, o_blk_data, e[127:0]);
      chk({tag, "_key"}, 128'(o_blk_is_key), 128'(e[128]));
    end
  endtask

  task automatic pop_chk(input string tag);
    head_chk(tag);
    i_blk_ready = 1'b1;
    cyc();
    i_blk_ready = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; i_shift_en = 1'b0; i_word_in = '0; i_data_type = 1'b0;
    i_flush = 1'b0; i_blk_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", 128'(o_blk_valid), 128'(1'b0));
    chk("rst_empty", 128'(o_empty), 128'(1'b1));
    chk("rst_full", 128'(o_full), 128'(1'b0));
    chk("rst_ovf", 128'(o_overflow), 128'(1'b0));
    chk("rst_wct", 128'(o_word_ct), 128'(0));
    chk("rst_cnt", 128'(o_blk_count), 128'(0));
    chk("rst_data", o_blk_data, 128'(0));
    chk("rst_key", 128'(o_blk_is_key), 128'(1'b0));
    n_rst = 1'b1;
    cyc();

    // Basic data block, with latency and word counter observed along the way
    shift(32'h00112233, 1'b0);
    shift(32'h44556677, 1'b0);
    chk("t1_wct2", 128'(o_word_ct), 128'(2));
    shift(32'h8899AABB, 1'b0);
    chk("t1_novalid", 128'(o_blk_valid), 128'(1'b0));
    sb.push_back({1'b0, sw(32'h00112233), sw(32'h44556677), sw(32'h8899AABB), sw(32'hCCDDEEFF)});
    shift(32'hCCDDEEFF, 1'b0);
    chk("t1_wct0", 128'(o_word_ct), 128'(0));
    chk("t1_cnt", 128'(o_blk_count), 128'(1));
`ifndef RX_BYTE_SWAP_EN
    chk("t1_literal", o_blk_data, 128'h00112233445566778899AABBCCDDEEFF);
`endif
    pop_chk("t1_pop");
    chk("t1_empty", 128'(o_empty), 128'(1'b1));

    // Tag latched on word 0 only
    send_block(32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 1'b1, 1'b1);
    chk("t2_key_lit", 128'(o_blk_is_key), 128'(1'b1));
    pop_chk("t2_pop");
    chk("t2_cnt", 128'(o_blk_count), 128'(2));

    // Fill, overflow drop, ordered drain
    send_block(32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003, 1'b0, 1'b1);
    chk("t3_notfull", 128'(o_full), 128'(1'b0));
    send_block(32'h20000000, 32'h20000001, 32'h20000002, 32'h20000003, 1'b1, 1'b1);
    chk("t3_full", 128'(o_full), 128'(1'b1));
    chk("t3_ovf0", 128'(o_overflow), 128'(1'b0));
    send_block(32'h30000000, 32'h30000001, 32'h30000002, 32'h30000003, 1'b0, 1'b0);
    chk("t3_ovf1", 128'(o_overflow), 128'(1'b1));
    chk("t3_cnt", 128'(o_blk_count), 128'(4));
    chk("t3_wct", 128'(o_word_ct), 128'(0));
    pop_chk("t3_popA");
    pop_chk("t3_popB");
    chk("t3_empty", 128'(o_empty), 128'(1'b1));
    i_blk_ready = 1'b1;
    cyc();
    i_blk_ready = 1'b0;
    chk("t3_idle_empty", 128'(o_empty), 128'(1'b1));
    chk("t3_idle_ovf", 128'(o_overflow), 128'(1'b1));

    // Flush mid-block with a pending block and a simultaneous shift
    send_block(32'h40000000, 32'h40000001, 32'h40000002, 32'h40000003, 1'b0, 1'b1);
    shift(32'h50000000, 1'b0);
    shift(32'h50000001, 1'b0);
    i_flush = 1'b1; i_shift_en = 1'b1; i_word_in = 32'h50000002; i_blk_ready = 1'b1;
    cyc();
    i_flush = 1'b0; i_shift_en = 1'b0; i_blk_ready = 1'b0;
    sb.delete();
    chk("t4_wct", 128'(o_word_ct), 128'(0));
    chk("t4_empty", 128'(o_empty), 128'(1'b1));
    chk("t4_valid", 128'(o_blk_valid), 128'(1'b0));
    chk("t4_ovf", 128'(o_overflow), 128'(1'b0));
    chk("t4_cnt", 128'(o_blk_count), 128'(0));
    send_block(32'h60000000, 32'h60000001, 32'h60000002, 32'h60000003, 1'b1, 1'b1);
    chk("t4_cnt1", 128'(o_blk_count), 128'(1));
    pop_chk("t4_pop");

    // Full FIFO: commit and pop on the same edge
    send_block(32'h70000000, 32'h70000001, 32'h70000002, 32'h70000003, 1'b0, 1'b1);
    send_block(32'h80000000, 32'h80000001, 32'h80000002, 32'h80000003, 1'b1, 1'b1);
    chk("t5_full", 128'(o_full), 128'(1'b1));
    shift(32'h90000000, 1'b1);
    shift(32'h90000001, 1'b0);
    shift(32'h90000002, 1'b0);
    head_chk("t5_popD");
    i_blk_ready = 1'b1;
    sb.push_back({1'b1, sw(32'h90000000), sw(32'h90000001), sw(32'h90000002), sw(32'h90000003)});
    shift(32'h90000003, 1'b0);
    i_blk_ready = 1'b0;
    chk("t5_full_kept", 128'(o_full), 128'(1'b1));
    chk("t5_ovf", 128'(o_overflow), 128'(1'b0));
    chk("t5_cnt", 128'(o_blk_count), 128'(4));
    pop_chk("t5_popE");
    pop_chk("t5_popF");
    chk("t5_empty", 128'(o_empty), 128'(1'b1));
    chk("t5_sb_drained", 128'(sb.size()), 128'(0));

    // Identical words; under RX_BYTE_SWAP_EN the head reads 0x33221100 x4
    send_block(32'h00112233, 32'h00112233, 32'h00112233, 32'h00112233, 1'b0, 1'b1);
`ifdef RX_BYTE_SWAP_EN
    chk("t6_swap_lit", o_blk_data, 128'h33221100332211003322110033221100);
`endif
    pop_chk("t6_pop");

    // Reset mid-block leaves nothing behind
    shift(32'hDEADBEEF, 1'b1);
    n_rst = 1'b0;
    #1;
    chk("t7_wct", 128'(o_word_ct), 128'(0));
    chk("t7_valid", 128'(o_blk_valid), 128'(1'b0));
    @(negedge clk);
    n_rst = 1'b1;
    cyc();
    chk("t7_cnt", 128'(o_blk_count), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
